btn_conditioner: RTL and testbench
==================================

BTN_CONDITIONER -- requirements
Module: btn_conditioner

Interface
REQ-001 SHALL have parameter N_BTN, default 2, number of button channels.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 1000000, consecutive stable samples required (20 ms at 50 MHz); legal range >= 2.
REQ-003 SHALL have parameter LONG_CYCLES, default 50000000, press duration that produces a long-press event; legal range > DEBOUNCE_CYCLES.
REQ-004 SHALL have parameter BTN_ACTIVE_LOW, default 1, where 1 means the raw pin reads 0 when pressed.
REQ-005 SHALL have port clk_clk, input, 1 bit: the single clock (fabric 50 MHz).
REQ-006 SHALL have port reset_reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port btn_raw, input, N_BTN bits: asynchronous board push-button pins.
REQ-008 SHALL have port btn_level, output, N_BTN bits: debounced level, 1 = pressed; drives btn_external_connection_export of soc_system.
REQ-009 SHALL have port btn_press, output, N_BTN bits: one-cycle pulse on each debounced press.
REQ-010 SHALL have port btn_release, output, N_BTN bits: one-cycle pulse on each debounced release.
REQ-011 SHALL have port btn_long, output, N_BTN bits: one-cycle pulse when a press has lasted LONG_CYCLES.

Function
REQ-012 SHALL pass each btn_raw bit through a 2-flop synchronizer, then XOR it with BTN_ACTIVE_LOW to form the active-high sample s.
REQ-013 SHALL run one independent FSM per channel with states RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT.
REQ-014 SHALL, in RELEASED with s=1, go to PRESS_WAIT and set the debounce counter to 1; with s=0, stay in RELEASED.
REQ-015 SHALL, in PRESS_WAIT with s=0, return to RELEASED; with s=1 and counter = DEBOUNCE_CYCLES-1, go to PRESSED; otherwise increment the counter.
REQ-016 SHALL, on entering PRESSED, set btn_level=1 and assert btn_press for exactly that cycle.
REQ-017 SHALL treat RELEASE_WAIT and the release transition symmetrically with s inverted; on entering RELEASED, btn_level=0 and btn_release pulses for one cycle.
REQ-018 SHALL make btn_level change exactly DEBOUNCE_CYCLES+2 rising edges after the first edge at which the stable new pin value is captured by flop 1.
REQ-019 SHALL treat any glitch shorter than DEBOUNCE_CYCLES samples as no event: btn_level unchanged and no pulses.
REQ-020 SHALL reset the long counter on entering PRESSED, increment it each cycle in PRESSED and RELEASE_WAIT, and saturate it at LONG_CYCLES.
REQ-021 SHALL pulse btn_long for one cycle when the long counter reaches LONG_CYCLES, at most once per press; a release before that point produces no btn_long.
REQ-022 SHALL drive all outputs from registers, with no combinational path from btn_raw.
REQ-023 SHALL size each counter as $clog2(max+1) bits so that it never wraps.
REQ-024 SHALL keep channels fully independent: simultaneous events on several channels give simultaneous pulses.

Reset
REQ-025 SHALL, while reset_reset_n=0, hold each FSM in RELEASED, clear all counters, drive btn_level, btn_press, btn_release and btn_long to 0, and load the synchronizer flops with the inactive pin level (BTN_ACTIVE_LOW).
REQ-026 SHALL, if a button is held across reset deassertion, require a full debounce again and then emit btn_press; no btn_release is generated by the reset itself.

Structure
REQ-027 SHALL place the FSM state enum (btn_state_t) and a counter-width function in package btn_pkg.
REQ-028 SHALL implement one channel (synchronizer, FSM, counters) as sub-module btn_debounce_ch, instantiated N_BTN times by a generate loop.

Verification
Benches run with DEBOUNCE_CYCLES=4, LONG_CYCLES=20, BTN_ACTIVE_LOW=1.
REQ-029 SHALL cover a clean press: btn_raw[0] 1->0 held -> btn_level[0]=1 and btn_press[0] pulses at edge 6 after capture; other channel stays idle.
REQ-030 SHALL cover a bounce: btn_raw[0] low 3 cycles, high 1, then low held -> exactly one btn_press[0], timed from the final fall.
REQ-031 SHALL cover a long press: hold 30 cycles -> btn_long[0] pulses exactly once, 20 cycles after btn_press[0]; release -> one btn_release[0].
REQ-032 SHALL cover a short press of 10 cycles -> btn_press then btn_release, with no btn_long.
REQ-033 SHALL cover reset mid-press: assert reset while btn_level[0]=1 -> all outputs 0 at once; deassert with the button still held -> btn_press[0] again after 6 edges.
REQ-034 SHALL cover simultaneous channels: both pins fall on the same edge -> btn_press = 2'b11 in the same cycle.

Source files
------------

// File: rtl/btn_pkg.sv
// rtl/btn_pkg.sv - shared state type and counter sizing for the button conditioner
package btn_pkg;

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_t;

    // Bits needed to hold 0..max_val without wrapping (never less than one bit).
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// rtl/btn_debounce_ch.sv - one button channel: synchronizer, debounce FSM, long-press counter
module btn_debounce_ch
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int LONG_CYCLES     = 50000000,
    parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_raw_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic long_o
);

    localparam int DW = cnt_width(DEBOUNCE_CYCLES - 1);
    localparam int LW = cnt_width(LONG_CYCLES);
    localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [LW-1:0] LONG_MAX = LW'(LONG_CYCLES);

    logic [1:0]    sync_q;
    logic          s_q;
    btn_state_t    state_q, state_d;
    logic [DW-1:0] db_cnt_q, db_cnt_d;
    logic [LW-1:0] long_cnt_q, long_cnt_d;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic          long_q, long_d;

    // Sync flops idle at the inactive pin level; s_q adds the stage that sets the
    // DEBOUNCE_CYCLES+2 edge latency from first capture to btn_level.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= {2{BTN_ACTIVE_LOW}};
            s_q    <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], btn_raw_i};
            s_q    <= sync_q[1] ^ BTN_ACTIVE_LOW;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= RELEASED;
            db_cnt_q   <= '0;
            long_cnt_q <= '0;
            level_q    <= 1'b0;
            press_q    <= 1'b0;
            release_q  <= 1'b0;
            long_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            db_cnt_q   <= db_cnt_d;
            long_cnt_q <= long_cnt_d;
            level_q    <= level_d;
            press_q    <= press_d;
            release_q  <= release_d;
            long_q     <= long_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        db_cnt_d   = db_cnt_q;
        long_cnt_d = long_cnt_q;
        level_d    = level_q;
        press_d    = 1'b0;
        release_d  = 1'b0;
        long_d     = 1'b0;

        // Release bounces keep counting so a press yields at most one long event.
        if ((state_q == PRESSED || state_q == RELEASE_WAIT) && long_cnt_q != LONG_MAX) begin
            long_cnt_d = long_cnt_q + 1'b1;
            long_d     = (long_cnt_d == LONG_MAX);
        end

        unique case (state_q)
            RELEASED: begin
                if (s_q) begin
                    state_d  = PRESS_WAIT;
                    db_cnt_d = DW'(1);
                end
            end
            PRESS_WAIT: begin
                if (!s_q) begin
                    state_d = RELEASED;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d    = PRESSED;
                    level_d    = 1'b1;
                    press_d    = 1'b1;
                    long_cnt_d = '0;
                end else begin
                    db_cnt_d = db_cnt_q + 1'b1;
                end
            end
            PRESSED: begin
                if (!s_q) begin
                    state_d  = RELEASE_WAIT;
                    db_cnt_d = DW'(1);
                end
            end
            RELEASE_WAIT: begin
                if (s_q) begin
                    state_d = PRESSED;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d   = RELEASED;
                    level_d   = 1'b0;
                    release_d = 1'b1;
                end else begin
                    db_cnt_d = db_cnt_q + 1'b1;
                end
            end
            default: state_d = RELEASED;
        endcase
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;
    assign long_o    = long_q;

endmodule

// File: rtl/btn_conditioner.sv
// rtl/btn_conditioner.sv - N_BTN independent debounced push-button channels with event pulses
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int N_BTN           = 2,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int LONG_CYCLES     = 50000000,
    parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
    input  logic             clk_clk,
    input  logic             reset_reset_n,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_long
);

    for (genvar g = 0; g < N_BTN; g++) begin : g_ch
        btn_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .LONG_CYCLES     (LONG_CYCLES),
            .BTN_ACTIVE_LOW  (BTN_ACTIVE_LOW)
        ) u_ch (
            .clk_i     (clk_clk),
            .rst_ni    (reset_reset_n),
            .btn_raw_i (btn_raw[g]),
            .level_o   (btn_level[g]),
            .press_o   (btn_press[g]),
            .release_o (btn_release[g]),
            .long_o    (btn_long[g])
        );
    end

endmodule

// File: tb/tb_btn_conditioner.sv
// tb/tb_btn_conditioner.sv - directed vector bench for btn_conditioner
module tb_btn_conditioner;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] raw;
    logic [1:0] level, press, rel, lng;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    btn_conditioner #(
        .N_BTN           (2),
        .DEBOUNCE_CYCLES (4),
        .LONG_CYCLES     (20),
        .BTN_ACTIVE_LOW  (1'b1)
    ) dut (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .btn_raw       (raw),
        .btn_level     (level),
        .btn_press     (press),
        .btn_release   (rel),
        .btn_long      (lng)
    );

    typedef struct {
        logic [1:0] raw;
        int         edges;
        logic [1:0] level;
        logic [1:0] press;
        logic [1:0] rel;
        logic [1:0] lng;
    } vec_t;

    vec_t vecs [0:17];

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Observes channel 0 events for a fixed number of edges; j=0 is the first edge.
    task automatic watch(input int edges, output int np, output int pa, output int nr,
                         output int ra, output int nl, output int la, output int other);
        np = 0; pa = -1; nr = 0; ra = -1; nl = 0; la = -1; other = 0;
        for (int j = 0; j < edges; j++) begin
            @(posedge clk);
            #1;
            if (press[0]) begin np++; pa = j; end
            if (rel[0])   begin nr++; ra = j; end
            if (lng[0])   begin nl++; la = j; end
            if (press[1] || rel[1] || lng[1]) other++;
        end
    endtask

    initial begin
        int np, pa, nr, ra, nl, la, oth;
        int np2, pa2, nr2, ra2, nl2, la2, oth2;

        vecs[0]  = '{2'b10, 6, 2'b00, 2'b00, 2'b00, 2'b00};
        vecs[1]  = '{2'b10, 1, 2'b01, 2'b01, 2'b00, 2'b00};
        vecs[2]  = '{2'b10, 1, 2'b01, 2'b00, 2'b00, 2'b00};
        vecs[3]  = '{2'b11, 6, 2'b01, 2'b00, 2'b00, 2'b00};
        vecs[4]  = '{2'b11, 1, 2'b00, 2'b00, 2'b01, 2'b00};
        vecs[5]  = '{2'b11, 1, 2'b00, 2'b00, 2'b00, 2'b00};
        vecs[6]  = '{2'b00, 6, 2'b00, 2'b00, 2'b00, 2'b00};
        vecs[7]  = '{2'b00, 1, 2'b11, 2'b11, 2'b00, 2'b00};
        vecs[8]  = '{2'b00, 1, 2'b11, 2'b00, 2'b00, 2'b00};
        vecs[9]  = '{2'b11, 6, 2'b11, 2'b00, 2'b00, 2'b00};
        vecs[10] = '{2'b11, 1, 2'b00, 2'b00, 2'b11, 2'b00};
        vecs[11] = '{2'b01, 3, 2'b00, 2'b00, 2'b00, 2'b00};
        vecs[12] = '{2'b11, 10, 2'b00, 2'b00, 2'b00, 2'b00};
        vecs[13] = '{2'b01, 4, 2'b00, 2'b00, 2'b00, 2'b00};
        vecs[14] = '{2'b11, 2, 2'b00, 2'b00, 2'b00, 2'b00};
        vecs[15] = '{2'b11, 1, 2'b10, 2'b10, 2'b00, 2'b00};
        vecs[16] = '{2'b11, 3, 2'b10, 2'b00, 2'b00, 2'b00};
        vecs[17] = '{2'b11, 1, 2'b00, 2'b00, 2'b10, 2'b00};

        rst_n = 1'b0;
        raw   = 2'b11;
        step(3);
        check("reset_outputs", int'({level, press, rel, lng}), 0);
        rst_n = 1'b1;
        step(1);
        check("idle_after_reset", int'({level, press, rel, lng}), 0);

        for (int i = 0; i < 18; i++) begin
            raw = vecs[i].raw;
            step(vecs[i].edges);
            check($sformatf("vec%0d", i), int'({level, press, rel, lng}),
                  int'({vecs[i].level, vecs[i].press, vecs[i].rel, vecs[i].lng}));
        end

        // Bounce: low 3, high 1, then low held; press timed from the final fall.
        raw = 2'b10; step(3);
        raw = 2'b11; step(1);
        raw = 2'b10;
        watch(15, np, pa, nr, ra, nl, la, oth);
        check("bounce_press_count", np, 1);
        check("bounce_press_edge", pa, 6);
        check("bounce_level", int'(level), 1);
        raw = 2'b11;
        watch(10, np, pa, nr, ra, nl, la, oth);
        check("bounce_release_count", nr, 1);

        // Long press.
        raw = 2'b10;
        watch(40, np, pa, nr, ra, nl, la, oth);
        check("long_press_edge", pa, 6);
        check("long_count", nl, 1);
        check("long_edge", la, 26);
        check("long_no_release", nr, 0);
        raw = 2'b11;
        watch(10, np, pa, nr, ra, nl, la, oth);
        check("long_release_count", nr, 1);
        check("long_release_edge", ra, 6);
        check("long_none_after", nl, 0);

        // Short press of 10 cycles.
        raw = 2'b10;
        watch(10, np, pa, nr, ra, nl, la, oth);
        raw = 2'b11;
        watch(20, np2, pa2, nr2, ra2, nl2, la2, oth2);
        check("short_press", np + np2, 1);
        check("short_press_edge", pa, 6);
        check("short_release", nr + nr2, 1);
        check("short_release_edge", ra2, 6);
        check("short_no_long", nl + nl2, 0);
        check("short_ch1_idle", oth + oth2, 0);

        // Reset while pressed, button still held afterwards.
        raw = 2'b10;
        step(8);
        check("pre_reset_level", int'(level), 1);
        rst_n = 1'b0;
        #1;
        check("reset_async_clear", int'({level, press, rel, lng}), 0);
        step(2);
        check("reset_hold_clear", int'({level, press, rel, lng}), 0);
        rst_n = 1'b1;
        watch(12, np, pa, nr, ra, nl, la, oth);
        check("rst_repress_count", np, 1);
        check("rst_repress_edge", pa, 6);
        check("rst_no_release", nr, 0);
        raw = 2'b11;
        watch(10, np, pa, nr, ra, nl, la, oth);
        check("rst_final_release", nr, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
